// File: rtl/game_pkg.sv
// Shared game geometry and the per-slot bullet record for the projectile engine.
// The dy field exists only when BULLET_POOL_AIM_EN is defined.
package game_pkg;

  localparam int BULLET_X       = 4;
  localparam int BULLET_Y       = 2;
  localparam int BULLET_STEP_X  = 8;
  localparam int PLAYER_X       = 16;
  localparam int PLAYER_Y       = 32;
  localparam int SQUAT_PLAYER_Y = 12;
  localparam int MAP_X          = 320;
  localparam int MAP_Y          = 240;

  typedef struct packed {
    logic               isE;
    logic signed [10:0] x;
    logic signed [9:0]  y;
`ifdef BULLET_POOL_AIM_EN
    logic signed [1:0]  dy;
`endif
  } bullet_t;

  function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
    return v[11] ? -v : v;
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Fire/target inputs and per-slot render/hit outputs of the bullet pool.
interface bullet_pool_if #(parameter int N_SLOTS = 4);

  localparam int CNT_W = $clog2(N_SLOTS + 1);

  logic                     tick;
  logic                     attack;
  logic                     defend;
  logic signed [10:0]       xShooter;
  logic signed [9:0]        yShooter;
  logic signed [10:0]       xTarget;
  logic signed [9:0]        yTarget;
  logic                     isQ;
  logic [N_SLOTS-1:0][10:0] x;
  logic [N_SLOTS-1:0][9:0]  y;
  logic [N_SLOTS-1:0]       isE;
  logic                     isHit;
  logic [CNT_W-1:0]         hitCnt;
  logic                     fireAck;
  logic                     full;

  modport master (
    output tick, attack, defend, xShooter, yShooter, xTarget, yTarget, isQ,
    input  x, y, isE, isHit, hitCnt, fireAck, full
  );

  modport slave (
    input  tick, attack, defend, xShooter, yShooter, xTarget, yTarget, isQ,
    output x, y, isE, isHit, hitCnt, fireAck, full
  );

endinterface

// File: rtl/bullet_slot.sv
// One bullet: spawn capture, per-tick motion, hitbox and map-edge tests.
// Vertical stepping and the y-edge test exist only with BULLET_POOL_AIM_EN.
module bullet_slot
  import game_pkg::*;
#(
  parameter int STEP_X   = BULLET_STEP_X,
  parameter bit DIR_LEFT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spawn,
  input  logic signed [10:0] spawn_x,
  input  logic signed [9:0]  spawn_y,
`ifdef BULLET_POOL_AIM_EN
  input  logic signed [1:0]  spawn_dy,
`endif
  input  logic               tick,
  input  logic signed [10:0] x_target,
  input  logic signed [9:0]  y_target,
  input  logic               is_q,
  output logic               alive,
  output logic               hit,
  output logic signed [10:0] x,
  output logic signed [9:0]  y
);

  localparam logic signed [11:0] HIT_X   = 12'(PLAYER_X + BULLET_X);
  localparam logic signed [11:0] STAND_H = 12'(PLAYER_Y);
  localparam logic signed [11:0] SQUAT_H = 12'(SQUAT_PLAYER_Y);
  localparam logic signed [11:0] HALF_BY = 12'(BULLET_Y);
  localparam logic signed [11:0] EXIT_L  = 12'(BULLET_X - MAP_X);
  localparam logic signed [11:0] EXIT_R  = 12'(MAP_X - BULLET_X);

  bullet_t            st_q, st_d;
  logic signed [10:0] x_next;
  logic signed [11:0] xn_ext, dx, h, y_ext, yt_ext, dy_t;
  logic               hit_x, hit_y, exit_x, exit_y;
`ifdef BULLET_POOL_AIM_EN
  localparam logic signed [11:0] EXIT_Y = 12'(MAP_Y - BULLET_Y);
  logic signed [9:0]  y_next;
`endif

  always_comb begin
    x_next = DIR_LEFT ? (st_q.x - 11'(STEP_X)) : (st_q.x + 11'(STEP_X));
    xn_ext = {x_next[10], x_next};
    dx     = xn_ext - {x_target[10], x_target};
    hit_x  = abs12(dx) < HIT_X;

    // Target hitbox centre sits H above yTarget, with half-height H.
    h      = is_q ? SQUAT_H : STAND_H;
    y_ext  = {{2{st_q.y[9]}}, st_q.y};
    yt_ext = {{2{y_target[9]}}, y_target};
    dy_t   = y_ext - (yt_ext + h);
    hit_y  = abs12(dy_t) < (HALF_BY + h);

    exit_x = DIR_LEFT ? (xn_ext < EXIT_L) : (xn_ext > EXIT_R);
`ifdef BULLET_POOL_AIM_EN
    y_next = st_q.y + {{8{st_q.dy[1]}}, st_q.dy};
    exit_y = abs12({{2{y_next[9]}}, y_next}) >= EXIT_Y;
`else
    exit_y = 1'b0;
`endif

    hit  = tick && st_q.isE && hit_x && hit_y;
    st_d = st_q;
    if (spawn) begin
      st_d.isE = 1'b1;
      st_d.x   = spawn_x;
      st_d.y   = spawn_y;
`ifdef BULLET_POOL_AIM_EN
      st_d.dy  = spawn_dy;
`endif
    end else if (tick && st_q.isE) begin
      st_d.x = x_next;
`ifdef BULLET_POOL_AIM_EN
      st_d.y = y_next;
`endif
      if (hit || exit_x || exit_y) st_d.isE = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  assign alive = st_q.isE;
  assign x     = st_q.x;
  assign y     = st_q.y;

endmodule

// File: rtl/bullet_pool.sv
// N-slot enemy projectile engine: lowest-free-slot allocator, shot cooldown, hit popcount.
// Optional aimed vertical motion is enabled by defining BULLET_POOL_AIM_EN.
module bullet_pool
  import game_pkg::*;
#(
  parameter int N_SLOTS  = 4,
  parameter int COOLDOWN = 12,
  parameter int STEP_X   = BULLET_STEP_X,
  parameter bit DIR_LEFT = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  bullet_pool_if.slave bus
);

  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int CNT_W = $clog2(N_SLOTS + 1);

  logic [CD_W-1:0]    cd_q, cd_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               is_hit_q, is_hit_d;
  logic               fire_ack_q, fire_ack_d;
  logic [N_SLOTS-1:0] alive, hit, spawn;
  logic               full, fire_ok, found;
  logic signed [10:0] spawn_x;
`ifdef BULLET_POOL_AIM_EN
  logic signed [1:0]  spawn_dy;
`endif

  // full comes from registered alive flags, so a slot freed this tick is not reusable yet.
  always_comb begin
    full    = &alive;
    fire_ok = bus.attack && !bus.defend && (cd_q == '0) && !full;
    spawn_x = DIR_LEFT ? (bus.xShooter - 11'(PLAYER_X + BULLET_X))
                       : (bus.xShooter + 11'(PLAYER_X + BULLET_X));
`ifdef BULLET_POOL_AIM_EN
    if (bus.yTarget > bus.yShooter)      spawn_dy = 2'sb01;
    else if (bus.yTarget < bus.yShooter) spawn_dy = 2'sb11;
    else                                 spawn_dy = 2'sb00;
`endif

    spawn = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!alive[i] && !found) begin
        spawn[i] = fire_ok;
        found    = 1'b1;
      end
    end

    hit_cnt_d = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      hit_cnt_d = hit_cnt_d + CNT_W'(hit[i]);
    end
    is_hit_d   = |hit;
    fire_ack_d = fire_ok;

    cd_d = cd_q;
    if (fire_ok)                     cd_d = CD_W'(COOLDOWN);
    else if (bus.tick && cd_q != '0) cd_d = cd_q - 1'b1;
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    bullet_slot #(
      .STEP_X   (STEP_X),
      .DIR_LEFT (DIR_LEFT)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .spawn    (spawn[g]),
      .spawn_x  (spawn_x),
      .spawn_y  (bus.yShooter),
`ifdef BULLET_POOL_AIM_EN
      .spawn_dy (spawn_dy),
`endif
      .tick     (bus.tick),
      .x_target (bus.xTarget),
      .y_target (bus.yTarget),
      .is_q     (bus.isQ),
      .alive    (alive[g]),
      .hit      (hit[g]),
      .x        (bus.x[g]),
      .y        (bus.y[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q       <= '0;
      hit_cnt_q  <= '0;
      is_hit_q   <= 1'b0;
      fire_ack_q <= 1'b0;
    end else begin
      cd_q       <= cd_d;
      hit_cnt_q  <= hit_cnt_d;
      is_hit_q   <= is_hit_d;
      fire_ack_q <= fire_ack_d;
    end
  end

  assign bus.isE     = alive;
  assign bus.full    = full;
  assign bus.isHit   = is_hit_q;
  assign bus.hitCnt  = hit_cnt_q;
  assign bus.fireAck = fire_ack_q;

endmodule
